// File: rtl/multi_shift_engine_if.sv
// Bundle of control, data and status signals for multi_shift_engine.
// master drives commands, slave is the engine.
interface multi_shift_engine_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
);
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             shift_left;
   logic             shift_right;
   logic             serial_in;
   logic             start;
   logic [2:0]       mode;
   logic [AMT_W-1:0] amount;
   logic [WIDTH-1:0] current_value;
   logic             serial_out;
   logic             busy;
   logic             done;

   modport master (
      output load, load_value, shift_left, shift_right,
      output serial_in, start, mode, amount,
      input  current_value, serial_out, busy, done
   );

   modport slave (
      input  load, load_value, shift_left, shift_right,
      input  serial_in, start, mode, amount,
      output current_value, serial_out, busy, done
   );
endinterface

// File: rtl/multi_shift_engine.sv
// Universal shift register with a multi-cycle shift-by-amount engine.
// Load, single steps in IDLE, and a start/busy/done command.
module multi_shift_engine #(
   parameter int               WIDTH       = 8,
   parameter int               AMT_W       = 3,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   multi_shift_engine_if.slave   io_if
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam logic [2:0] M_LSL = 3'd0;
   localparam logic [2:0] M_LSR = 3'd1;
   localparam logic [2:0] M_ASR = 3'd2;
   localparam logic [2:0] M_ROL = 3'd3;
   localparam logic [2:0] M_ROR = 3'd4;

   state_t           r_state, w_state_nx;
   logic [WIDTH-1:0] r_val, w_val_nx;
   logic             r_sout, w_sout_nx;
   logic [2:0]       r_mode, w_mode_nx;
   logic [AMT_W-1:0] r_cnt, w_cnt_nx;
   logic             r_fill, w_fill_nx;
   logic [WIDTH:0]   w_res;

   // One step; result is {bit shifted out, new value}, modes 5-7 hold
   function automatic logic [WIDTH:0] f_step(
      input logic [2:0]       m,
      input logic             f,
      input logic [WIDTH-1:0] v,
      input logic             so
   );
      logic [WIDTH:0] r;
      r = {so, v};
      case (m)
         M_LSL:   r = {v[WIDTH-1], v[WIDTH-2:0], f};
         M_LSR:   r = {v[0], f, v[WIDTH-1:1]};
         M_ASR:   r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
         M_ROL:   r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
         M_ROR:   r = {v[0], v[0], v[WIDTH-1:1]};
         default: r = {so, v};
      endcase
      return r;
   endfunction

   always_comb begin
      w_state_nx = r_state;
      w_val_nx   = r_val;
      w_sout_nx  = r_sout;
      w_mode_nx  = r_mode;
      w_cnt_nx   = r_cnt;
      w_fill_nx  = r_fill;
      w_res      = {r_sout, r_val};
      if (io_if.load) begin
         w_val_nx   = io_if.load_value;
         w_state_nx = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (io_if.start) begin
                  w_mode_nx  = io_if.mode;
                  w_cnt_nx   = io_if.amount;
                  w_fill_nx  = io_if.serial_in;
                  w_state_nx = (io_if.amount != '0) ? S_SHIFT : S_DONE;
               end else if (io_if.shift_left) begin
                  w_res = f_step(M_LSL, io_if.serial_in, r_val, r_sout);
                  {w_sout_nx, w_val_nx} = w_res;
               end else if (io_if.shift_right) begin
                  w_res = f_step(M_LSR, io_if.serial_in, r_val, r_sout);
                  {w_sout_nx, w_val_nx} = w_res;
               end
            end
            S_SHIFT: begin
               w_res = f_step(r_mode, r_fill, r_val, r_sout);
               {w_sout_nx, w_val_nx} = w_res;
               w_cnt_nx = r_cnt - AMT_W'(1);
               if (r_cnt == AMT_W'(1)) w_state_nx = S_DONE;
            end
            S_DONE: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_val   <= RESET_VALUE;
         r_sout  <= 1'b0;
         r_mode  <= '0;
         r_cnt   <= '0;
         r_fill  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_val   <= w_val_nx;
         r_sout  <= w_sout_nx;
         r_mode  <= w_mode_nx;
         r_cnt   <= w_cnt_nx;
         r_fill  <= w_fill_nx;
      end
   end

   assign io_if.current_value = r_val;
   assign io_if.serial_out    = r_sout;
   assign io_if.busy          = (r_state != S_IDLE);
   assign io_if.done          = (r_state == S_DONE);
endmodule

// File: tb/tb_multi_shift_engine.sv
// Scoreboard bench for multi_shift_engine: directed cases plus
// random loads, single steps and shift commands against a model.
module tb_multi_shift_engine;
   localparam int W = 8;
   localparam int A = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [W-1:0] m_val;
   logic         m_sout;
   logic [W:0]   sb[$];

   multi_shift_engine_if #(.WIDTH(W), .AMT_W(A)) bus ();

   multi_shift_engine #(.WIDTH(W), .AMT_W(A), .RESET_VALUE('0)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .io_if (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Whole-command result from the shift rules: {last bit out, value}
   function automatic logic [W:0] ref_cmd(input int m, input int n,
      input logic f, input logic [W-1:0] v, input logic so);
      logic [2*W-1:0] t;
      logic [W-1:0]   r;
      logic           o;
      int             k;
      if (n == 0 || m > 4) return {so, v};
      k = n % W;
      case (m)
         0: begin
            t = {v, {W{f}}};
            o = t[2*W-n];
            t = t << n;
            r = t[2*W-1:W];
         end
         1: begin
            t = {{W{f}}, v};
            o = t[n-1];
            t = t >> n;
            r = t[W-1:0];
         end
         2: begin
            t = {{W{v[W-1]}}, v};
            o = t[n-1];
            t = t >> n;
            r = t[W-1:0];
         end
         3: begin
            t = {v, v} << k;
            r = t[2*W-1:W];
            o = r[0];
         end
         default: begin
            t = {v, v} >> k;
            r = t[W-1:0];
            o = r[W-1];
         end
      endcase
      return {o, r};
   endfunction

   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexp_done act=1 exp=0");
         end else begin
            logic [W:0] e;
            e = sb.pop_front();
            chk("sb_val", bus.current_value, e[W-1:0]);
            chk("sb_sout", bus.serial_out, e[W]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [W-1:0] v);
      bus.load = 1'b1;
      bus.load_value = v;
      tick();
      bus.load = 1'b0;
      m_val = v;
      chk("load_val", bus.current_value, m_val);
      chk("load_sout", bus.serial_out, m_sout);
   endtask

   task automatic do_step(input logic l, input logic r, input logic f);
      logic [W:0] e;
      e = {m_sout, m_val};
      if (l) e = ref_cmd(0, 1, f, m_val, m_sout);
      else if (r) e = ref_cmd(1, 1, f, m_val, m_sout);
      bus.shift_left = l;
      bus.shift_right = r;
      bus.serial_in = f;
      tick();
      bus.shift_left = 1'b0;
      bus.shift_right = 1'b0;
      {m_sout, m_val} = e;
      chk("step_val", bus.current_value, m_val);
      chk("step_sout", bus.serial_out, m_sout);
   endtask

   task automatic do_cmd(input int m, input int n, input logic f);
      logic [W:0] e;
      int bc;
      int dat;
      e = ref_cmd(m, n, f, m_val, m_sout);
      sb.push_back(e);
      bus.start = 1'b1;
      bus.mode = m[2:0];
      bus.amount = n[A-1:0];
      bus.serial_in = f;
      tick();
      bus.start = 1'b0;
      bc = 0;
      dat = -1;
      while (bus.busy && bc < 40) begin
         if (bus.done) dat = bc;
         bus.serial_in = 1'($urandom);
         bus.shift_left = 1'($urandom);
         bus.start = 1'($urandom);
         bc++;
         tick();
      end
      bus.shift_left = 1'b0;
      bus.start = 1'b0;
      chk("busy_len", bc, n + 1);
      chk("done_at", dat, n);
      {m_sout, m_val} = e;
      chk("idle_val", bus.current_value, m_val);
   endtask

   initial begin
      bus.load = 1'b0;
      bus.load_value = '0;
      bus.shift_left = 1'b0;
      bus.shift_right = 1'b0;
      bus.serial_in = 1'b0;
      bus.start = 1'b0;
      bus.mode = '0;
      bus.amount = '0;
      m_val = '0;
      m_sout = 1'b0;
      rst = 1'b1;
      tick();
      chk("rst_val", bus.current_value, 8'h00);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_sout", bus.serial_out, 1'b0);
      rst = 1'b0;

      do_load(8'hB4);
      do_cmd(0, 3, 1'b0);
      chk("lsl3_val", bus.current_value, 8'hA0);
      chk("lsl3_sout", bus.serial_out, 1'b1);

      do_load(8'h81);
      do_cmd(2, 2, 1'b1);
      chk("asr2_val", bus.current_value, 8'hE0);
      chk("asr2_sout", bus.serial_out, 1'b0);
      do_cmd(4, 1, 1'b0);
      chk("ror1_val", bus.current_value, 8'h70);

      do_load(8'h5A);
      do_cmd(3, 0, 1'b0);
      chk("rol0_val", bus.current_value, 8'h5A);
      do_cmd(3, 7, 1'b0);
      chk("rol7_val", bus.current_value, 8'h2D);

      do_load(8'hFF);
      bus.start = 1'b1;
      bus.mode = 3'd1;
      bus.amount = 3'd5;
      bus.serial_in = 1'b0;
      tick();
      tick();
      tick();
      chk("abort_mid_val", bus.current_value, 8'h3F);
      chk("abort_mid_sout", bus.serial_out, 1'b1);
      bus.load = 1'b1;
      bus.load_value = 8'h3C;
      bus.start = 1'b0;
      tick();
      bus.load = 1'b0;
      chk("abort_val", bus.current_value, 8'h3C);
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_done", bus.done, 1'b0);
      m_val = 8'h3C;
      m_sout = 1'b1;
      repeat (8) tick();
      chk("abort_hold", bus.current_value, 8'h3C);

      do_load(8'h01);
      do_step(1'b1, 1'b0, 1'b1);
      chk("sl_val", bus.current_value, 8'h03);
      do_step(1'b1, 1'b1, 1'b0);
      chk("lr_val", bus.current_value, 8'h06);
      do_step(1'b0, 1'b1, 1'b1);

      do_load(8'h96);
      bus.start = 1'b1;
      bus.mode = 3'd3;
      bus.amount = 3'd5;
      tick();
      bus.start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstc_val", bus.current_value, 8'h00);
      chk("rstc_busy", bus.busy, 1'b0);
      chk("rstc_done", bus.done, 1'b0);
      chk("rstc_sout", bus.serial_out, 1'b0);
      m_val = '0;
      m_sout = 1'b0;
      tick();

      repeat (80) begin
         case ($urandom_range(0, 2))
            0: do_load(W'($urandom));
            1: do_step(1'($urandom), 1'($urandom), 1'($urandom));
            default: do_cmd($urandom_range(0, 7), $urandom_range(0, 7),
                            1'($urandom));
         endcase
      end
      tick();
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
